// File: rtl/sensor_stream_fifo.sv
// Single-clock streaming FIFO for the sensor path: FWFT or registered read,
// programmable almost-full/almost-empty, occupancy count, flush and sticky error flags.
module sensor_stream_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_set;
  logic                  unf_set;

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Handshake: wr_en/rd_en are requests held for one cycle; a transfer happens
  // on the edge where wr_acc/rd_acc is high. A read frees its slot in the same
  // cycle, so a full FIFO still accepts a write paired with a read. Requests
  // made while flush is high are ignored and never flag an error.
  assign rd_acc  = ~flush & rd_en & ~empty;
  assign wr_acc  = ~flush & wr_en & (~full | rd_acc);
  assign ovf_set = ~flush & wr_en & full & ~rd_acc;
  assign unf_set = ~flush & rd_en & empty;

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // A new error event wins over clr_err; flush leaves the flags alone.
      overflow_q  <= ovf_set | (overflow_q & ~clr_err);
      underflow_q <= unf_set | (underflow_q & ~clr_err);
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_acc, rd_acc})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is driven straight from the array; forced to 0 while empty
      // so stale contents never appear on the bus.
      assign rd_data  = empty ? '0 : mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sensor_stream_fifo.sv
// Bench for sensor_stream_fifo: an FWFT and a registered-read instance share
// one stimulus stream and are checked against a queue-based reference model.
module tb_sensor_stream_fifo;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int AW = 2;
  localparam int AF = 3;
  localparam int AE = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, clr_err, wr_en, rd_en;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] f_rd_data, r_rd_data;
  logic          f_rd_valid, r_rd_valid, f_full, r_full, f_empty, r_empty;
  logic          f_afull, r_afull, f_aempty, r_aempty, f_ovf, r_ovf, f_unf, r_unf;
  logic [AW:0]   f_count, r_count;

  sensor_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf));

  sensor_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(0)) dut_r (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(r_rd_data), .rd_valid(r_rd_valid), .full(r_full), .empty(r_empty),
    .almost_full(r_afull), .almost_empty(r_aempty), .count(r_count),
    .overflow(r_ovf), .underflow(r_unf));

  // reference model
  logic [DW-1:0] exp_q[$];
  logic          m_ovf, m_unf, m_rvalid;
  logic [DW-1:0] m_rdata;
  int            total = 0;
  int            bad = 0;

  // driver: apply one cycle of inputs, advance the model at the edge, settle
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic c, input logic rs);
    int   n;
    logic racc, wacc;
    wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c; rst_n = rs;
    @(posedge clk);
    if (!rs) begin
      exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    end else if (f) begin
      exp_q.delete(); m_rvalid = 1'b0;
      if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end else begin
      n = exp_q.size();
      racc = r && (n > 0);
      wacc = w && ((n < DP) || racc);
      m_rvalid = racc;
      if (racc) m_rdata = exp_q.pop_front();
      if (wacc) exp_q.push_back(d);
      m_ovf = (w && n == DP && !racc) || (m_ovf && !c);
      m_unf = (r && n == 0) || (m_unf && !c);
    end
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic rd();                      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1); endtask
  task automatic idle();                    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

  task automatic test_reset();
    logic [17:0] obs;
    rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    // {count, full, empty, afull, aempty, ovf, unf, rd_valid, rd_data}
    obs = {f_count, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf, f_rd_valid, f_rd_data};
    total++;
    if (obs !== {3'd0, 6'b010100, 1'b0, 8'h00}) begin
      bad++; $display("FAIL reset_fwft actual=%h required=%h", obs, {3'd0, 6'b010100, 9'h0});
    end
    obs = {r_count, r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf, r_rd_valid, r_rd_data};
    total++;
    if (obs !== {3'd0, 6'b010100, 1'b0, 8'h00}) begin
      bad++; $display("FAIL reset_reg actual=%h required=%h", obs, {3'd0, 6'b010100, 9'h0});
    end
    idle();
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] vals[4];
    logic [3:0]    obs, req;
    vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      wr(vals[i]);
      obs = {f_full, f_empty, f_afull, f_aempty};
      req = {(i + 1 == 4), 1'b0, (i + 1 >= 3), (i + 1 <= 1)};
      total++;
      if (obs !== req || f_count !== 3'(i + 1) || r_count !== 3'(i + 1)) begin
        bad++; $display("FAIL fill_status[%0d] actual=%b/%0d/%0d required=%b/%0d", i, obs,
                        f_count, r_count, req, i + 1);
      end
      total++;
      if (f_rd_data !== 8'hA1 || f_rd_valid !== 1'b1) begin
        bad++; $display("FAIL fill_fwft_head actual=%h required=a1", f_rd_data);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (f_rd_data !== vals[i] || f_rd_valid !== 1'b1) begin
        bad++; $display("FAIL drain_fwft[%0d] actual=%h required=%h", i, f_rd_data, vals[i]);
      end
      rd();
      total++;
      if (r_rd_data !== vals[i] || r_rd_valid !== 1'b1) begin
        bad++; $display("FAIL drain_reg[%0d] actual=%h/%b required=%h/1", i, r_rd_data,
                        r_rd_valid, vals[i]);
      end
    end
    idle();
    total++;
    if (r_rd_valid !== 1'b0 || r_rd_data !== 8'hD4 || f_empty !== 1'b1 || f_rd_valid !== 1'b0) begin
      bad++; $display("FAIL drain_end actual=%b/%h/%b required=0/d4/1", r_rd_valid, r_rd_data, f_empty);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] tail[4];
    tail = '{8'h11, 8'h12, 8'h13, 8'hF6};
    for (int i = 0; i < 4; i++) wr(8'(8'h10 + i));
    step(1'b1, 8'hE5, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (f_ovf !== 1'b1 || r_ovf !== 1'b1 || f_count !== 3'd4 || f_unf !== 1'b0) begin
      bad++; $display("FAIL ovf_set actual=%b/%b/%0d required=1/1/4", f_ovf, r_ovf, f_count);
    end
    step(1'b1, 8'hF6, 1'b1, 1'b0, 1'b0, 1'b1);
    total++;
    if (r_rd_data !== 8'h10 || r_count !== 3'd4 || f_full !== 1'b1) begin
      bad++; $display("FAIL full_rw actual=%h/%0d required=10/4", r_rd_data, r_count);
    end
    for (int i = 0; i < 4; i++) begin
      rd();
      total++;
      if (r_rd_data !== tail[i]) begin
        bad++; $display("FAIL ovf_drain[%0d] actual=%h required=%h", i, r_rd_data, tail[i]);
      end
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (f_ovf !== 1'b0 || r_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clear actual=%b/%b required=0/0", f_ovf, r_ovf);
    end
  endtask

  task automatic test_underflow();
    rd();
    total++;
    if (f_unf !== 1'b1 || f_count !== 3'd0 || r_rd_valid !== 1'b0) begin
      bad++; $display("FAIL unf_set actual=%b/%0d/%b required=1/0/0", f_unf, f_count, r_rd_valid);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'hA7, 1'b1, 1'b0, 1'b0, 1'b1);
    total++;
    if (f_unf !== 1'b1 || r_unf !== 1'b1 || f_count !== 3'd1 || f_rd_data !== 8'hA7) begin
      bad++; $display("FAIL empty_rw actual=%b/%0d/%h required=1/1/a7", f_unf, f_count, f_rd_data);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if ({f_ovf, f_unf, r_ovf, r_unf} !== 4'b0000) begin
      bad++; $display("FAIL unf_clear actual=%b required=0000", {f_ovf, f_unf, r_ovf, r_unf});
    end
    // error event in the same cycle as clr_err must win
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    total++;
    if (f_unf !== 1'b0 || r_rd_data !== 8'hA7) begin
      bad++; $display("FAIL pop_a7 actual=%b/%h required=0/a7", f_unf, r_rd_data);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    total++;
    if (f_unf !== 1'b1 || r_unf !== 1'b1) begin
      bad++; $display("FAIL set_beats_clr actual=%b/%b required=1/1", f_unf, r_unf);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      wr(8'(i));
      total++;
      if (f_count !== 3'd1 || f_rd_data !== 8'(i)) begin
        bad++; $display("FAIL wrap_wr[%0d] actual=%0d/%h required=1/%h", i, f_count, f_rd_data, i);
      end
      rd();
      total++;
      if (r_rd_data !== 8'(i) || r_count !== 3'd0) begin
        bad++; $display("FAIL wrap_rd[%0d] actual=%h/%0d required=%h/0", i, r_rd_data, r_count, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    wr(8'h30);
    for (int i = 1; i < 9; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (r_rd_data !== 8'(8'h30 + i - 1) || r_rd_valid !== 1'b1 || r_count !== 3'd1) begin
        bad++; $display("FAIL b2b_empty1[%0d] actual=%h/%0d required=%h/1", i, r_rd_data,
                        r_count, 8'h30 + i - 1);
      end
    end
    rd();
    for (int i = 0; i < 4; i++) wr(8'(8'h40 + i));
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(8'h44 + i), 1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (r_rd_data !== 8'(8'h40 + i) || f_full !== 1'b1 || f_ovf !== 1'b0) begin
        bad++; $display("FAIL b2b_full[%0d] actual=%h/%b/%b required=%h/1/0", i, r_rd_data,
                        f_full, f_ovf, 8'h40 + i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      rd();
      total++;
      if (r_rd_data !== 8'(8'h46 + i)) begin
        bad++; $display("FAIL b2b_drain[%0d] actual=%h required=%h", i, r_rd_data, 8'h46 + i);
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) wr(8'(8'h70 + i));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if ({f_count, f_empty, f_ovf, f_unf, r_ovf, r_unf, r_rd_valid} !== {3'd0, 6'b100000}) begin
      bad++; $display("FAIL flush actual=%0d/%b required=0/100000", f_count,
                      {f_empty, f_ovf, f_unf, r_ovf, r_unf, r_rd_valid});
    end
    wr(8'h88);
    total++;
    if (f_rd_data !== 8'h88 || f_count !== 3'd1) begin
      bad++; $display("FAIL post_flush actual=%h/%0d required=88/1", f_rd_data, f_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] obs;
    wr(8'h91); wr(8'h92); rd(); rd();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    wr(8'h93);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    obs = {r_count, r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf, r_rd_valid, r_rd_data};
    total++;
    if (obs !== {3'd0, 6'b010100, 1'b0, 8'h00} || f_count !== 3'd0 || f_rd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid actual=%h required=%h", obs, {3'd0, 6'b010100, 9'h0});
    end
    idle();
  endtask

  task automatic test_random();
    logic [17:0] obs, req;
    int          n, pw, pr;
    logic        w, r, f, c, rs;
    for (int i = 0; i < 900; i++) begin
      case ((i / 30) % 3)
        0:       begin pw = 80; pr = 25; end
        1:       begin pw = 25; pr = 80; end
        default: begin pw = 60; pr = 60; end
      endcase
      w  = ($urandom_range(0, 99) < pw);
      r  = ($urandom_range(0, 99) < pr);
      f  = ($urandom_range(0, 99) < 2);
      c  = !f && ($urandom_range(0, 99) < 6);
      rs = ($urandom_range(0, 199) != 0);
      step(w, 8'($urandom), r, f, c, rs);
      n = exp_q.size();
      req = {3'(n), (n == DP), (n == 0), (n >= AF), (n <= AE), m_ovf, m_unf,
             (n > 0), (n > 0) ? exp_q[0] : 8'h00};
      obs = {f_count, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf, f_rd_valid, f_rd_data};
      total++;
      if (obs !== req) begin
        bad++; $display("FAIL rand_fwft[%0d] actual=%h required=%h", i, obs, req);
      end
      req = {3'(n), (n == DP), (n == 0), (n >= AF), (n <= AE), m_ovf, m_unf, m_rvalid, m_rdata};
      obs = {r_count, r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf, r_rd_valid, r_rd_data};
      total++;
      if (obs !== req) begin
        bad++; $display("FAIL rand_reg[%0d] actual=%h required=%h", i, obs, req);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
